frame_src_arbiter: RTL and testbench

Shares the single frame path into `frame_buffer` between the two streaming frame sources, `uart_reciver` and `frame_gen`. It grants ownership according to `display_mode`, including an auto mode that prefers UART and falls back to the generator. It holds one pending frame per grant and releases frames only on the Display `sync` boundary, so source switches and frame updates never tear. It also produces the delivered-frame count shown on `seg7`.

---
 rtl/frame_src_arbiter_pkg.sv | 23 ++
 rtl/frame_src_arbiter_uart_activity_timer.sv | 30 +++
 rtl/frame_src_arbiter.sv | 151 +++++++++++++++
 tb/tb_frame_src_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_src_arbiter_pkg.sv
// Shared constants for the frame source arbiter: display-mode and owner encodings, frame width.
// The auto-fallback feature is selected at build time with the ARB_AUTO_FALLBACK_EN macro.
package frame_src_arbiter_pkg;

  localparam int FRAME_W = 512;

  localparam logic [1:0] STATIC_MODE = 2'b00;
  localparam logic [1:0] AUTO_MODE   = 2'b01;
  localparam logic [1:0] GEN_MODE    = 2'b10;
  localparam logic [1:0] UART_MODE   = 2'b11;

  // Owner encoding is shared with frame_buffer and the top level.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_GEN  = 2'b10,
    OWN_UART = 2'b11
  } owner_e;

  function automatic logic is_owner(input owner_e cur, input owner_e who);
    return cur == who;
  endfunction

endpackage

// File: rtl/frame_src_arbiter_uart_activity_timer.sv
// Saturating idle counter: reports UART as alive until TIMEOUT cycles pass without a handshake.
// Only instantiated when ARB_AUTO_FALLBACK_EN is defined.
module uart_activity_timer #(
  parameter int unsigned TIMEOUT = 100_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic uart_hs,
  output logic uart_alive
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] idle_cnt;

  // Reset to LIMIT so the UART is considered silent until it proves otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt <= LIMIT;
    end else if (uart_hs) begin
      idle_cnt <= '0;
    end else if (idle_cnt != LIMIT) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  assign uart_alive = idle_cnt < LIMIT;

endmodule

// File: rtl/frame_src_arbiter.sv
// Grants the single frame path to UART or generator by display_mode and releases one
// buffered frame per Display sync. Build option: ARB_AUTO_FALLBACK_EN enables auto mode.
module frame_src_arbiter
  import frame_src_arbiter_pkg::*;
#(
  parameter int unsigned UART_TIMEOUT = 100_000_000,
  parameter int          CNT_W        = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [1:0]         display_mode,
  input  logic               sync,
  input  logic [FRAME_W-1:0] uart_frame_flat,
  input  logic               uart_valid,
  output logic               uart_ready,
  input  logic [FRAME_W-1:0] gen_frame_flat,
  input  logic               gen_valid,
  output logic               gen_ready,
  output logic [FRAME_W-1:0] frame_cube_flat,
  output logic               frame_valid,
  output logic [1:0]         owner,
  output logic [CNT_W-1:0]   frame_cnt
);

  owner_e             owner_q;
  owner_e             owner_d;
  owner_e             target;
  logic               owner_change;

  logic               full_q;
  logic [FRAME_W-1:0] slot_q;
  logic [FRAME_W-1:0] cube_q;
  logic               valid_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               own_valid;
  logic [FRAME_W-1:0] own_data;
  logic               capture;
  logic               release_frame;

`ifdef ARB_AUTO_FALLBACK_EN
  logic uart_alive;

  uart_activity_timer #(
    .TIMEOUT (UART_TIMEOUT)
  ) u_uart_timer (
    .clk        (clk),
    .resetn     (resetn),
    .uart_hs    (uart_valid & uart_ready),
    .uart_alive (uart_alive)
  );
`endif

  always_comb begin
    target = OWN_NONE;
    case (display_mode)
      GEN_MODE:  target = OWN_GEN;
      UART_MODE: target = OWN_UART;
`ifdef ARB_AUTO_FALLBACK_EN
      AUTO_MODE: target = uart_alive ? OWN_UART : OWN_GEN;
`else
      AUTO_MODE: target = OWN_NONE;
`endif
      default:   target = OWN_NONE;
    endcase
  end

  // Owner FSM: state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Owner FSM: next state. Grants only move on a frame boundary so switches never tear.
  always_comb begin
    owner_d = owner_q;
    if (sync && (target != owner_q)) begin
      owner_d = target;
    end
  end

  assign owner_change = owner_d != owner_q;

  // Owner FSM: outputs.
  // Handshake: a frame transfers in a cycle where valid && ready. Ready depends only on
  // registered state (owner, full); the owner sees ready = ~full, every other source sees
  // ready = 1 and its frames are dropped, so no source ever stalls on a non-owned path.
  always_comb begin
    owner      = owner_q;
    uart_ready = !(is_owner(owner_q, OWN_UART) && full_q);
    gen_ready  = !(is_owner(owner_q, OWN_GEN) && full_q);
    own_valid  = 1'b0;
    own_data   = gen_frame_flat;
    case (owner_q)
      OWN_GEN: begin
        own_valid = gen_valid;
        own_data  = gen_frame_flat;
      end
      OWN_UART: begin
        own_valid = uart_valid;
        own_data  = uart_frame_flat;
      end
      default: begin
        own_valid = 1'b0;
        own_data  = gen_frame_flat;
      end
    endcase
  end

  assign capture       = own_valid && !full_q;
  assign release_frame = sync && full_q && !owner_change;

  // A change of owner drops whatever was pending, including a same-cycle capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full_q <= 1'b0;
      slot_q <= '0;
    end else if (owner_change) begin
      full_q <= 1'b0;
    end else if (release_frame) begin
      full_q <= 1'b0;
    end else if (capture) begin
      full_q <= 1'b1;
      slot_q <= own_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cube_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= release_frame;
      if (owner_change) begin
        cnt_q <= '0;
      end else if (release_frame) begin
        cube_q <= slot_q;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign frame_cube_flat = cube_q;
  assign frame_valid     = valid_q;
  assign frame_cnt       = cnt_q;

endmodule

// File: tb/tb_frame_src_arbiter.sv
// Randomized and directed stimulus for frame_src_arbiter, checked against a queue-based
// reference model; mode 01 expectations follow ARB_AUTO_FALLBACK_EN.
module tb_frame_src_arbiter;

  localparam int TO = 50;
  localparam int CW = 4;
  localparam int FW = 512;

  logic          clk;
  logic          resetn;
  logic [1:0]    display_mode;
  logic          sync;
  logic [FW-1:0] uart_frame_flat;
  logic          uart_valid;
  logic          uart_ready;
  logic [FW-1:0] gen_frame_flat;
  logic          gen_valid;
  logic          gen_ready;
  logic [FW-1:0] frame_cube_flat;
  logic          frame_valid;
  logic [1:0]    owner;
  logic [CW-1:0] frame_cnt;

  frame_src_arbiter #(
    .UART_TIMEOUT (TO),
    .CNT_W        (CW)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .display_mode    (display_mode),
    .sync            (sync),
    .uart_frame_flat (uart_frame_flat),
    .uart_valid      (uart_valid),
    .uart_ready      (uart_ready),
    .gen_frame_flat  (gen_frame_flat),
    .gen_valid       (gen_valid),
    .gen_ready       (gen_ready),
    .frame_cube_flat (frame_cube_flat),
    .frame_valid     (frame_valid),
    .owner           (owner),
    .frame_cnt       (frame_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the slot is a queue of at most one pending frame.
  logic [FW-1:0] exp_q[$];
  logic [1:0]    m_owner;
  logic [FW-1:0] m_cube;
  logic          m_valid;
  int            m_cnt;
  int            m_idle;

  int compared;
  int mismatched;
  int pulses;

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] r;
    for (int i = 0; i < FW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [1:0] model_target();
    case (display_mode)
      2'b10:   return 2'b10;
      2'b11:   return 2'b11;
`ifdef ARB_AUTO_FALLBACK_EN
      2'b01:   return (m_idle < TO) ? 2'b11 : 2'b10;
`endif
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    m_owner = 2'b00;
    exp_q.delete();
    m_cube  = '0;
    m_valid = 1'b0;
    m_cnt   = 0;
    m_idle  = TO;
  endtask

  task automatic chk(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    chk("owner", FW'(owner), FW'(m_owner));
    chk("uart_ready", FW'(uart_ready), FW'(!(m_owner == 2'b11 && exp_q.size() != 0)));
    chk("gen_ready", FW'(gen_ready), FW'(!(m_owner == 2'b10 && exp_q.size() != 0)));
    chk("frame_valid", FW'(frame_valid), FW'(m_valid));
    chk("frame_cnt", FW'(frame_cnt), FW'(m_cnt[CW-1:0]));
    chk("frame_cube", frame_cube_flat, m_cube);
  endtask

  // One clock: advance the model from the inputs present at the edge, then compare.
  task automatic cycle();
    logic [1:0]    tgt;
    logic          u_rdy;
    logic          own_v;
    logic [FW-1:0] own_d;
    tgt   = model_target();
    u_rdy = !(m_owner == 2'b11 && exp_q.size() != 0);
    own_v = (m_owner == 2'b10) ? gen_valid : (m_owner == 2'b11) ? uart_valid : 1'b0;
    own_d = (m_owner == 2'b11) ? uart_frame_flat : gen_frame_flat;
    if (sync && tgt != m_owner) begin
      m_owner = tgt;
      exp_q.delete();
      m_cnt   = 0;
      m_valid = 1'b0;
    end else if (sync && exp_q.size() != 0) begin
      m_cube  = exp_q.pop_front();
      m_valid = 1'b1;
      m_cnt   = (m_cnt + 1) % (1 << CW);
    end else begin
      m_valid = 1'b0;
      if (own_v && exp_q.size() == 0) exp_q.push_back(own_d);
    end
    m_idle = (uart_valid && u_rdy) ? 0 : ((m_idle < TO) ? m_idle + 1 : TO);
    @(posedge clk);
    #1;
    if (frame_valid) pulses++;
    check_all();
  endtask

  // Driver: apply one cycle of inputs and clock it.
  task automatic drive(input logic s, input logic gv, input logic [FW-1:0] gd,
                       input logic uv, input logic [FW-1:0] ud);
    sync            = s;
    gen_valid       = gv;
    gen_frame_flat  = gd;
    uart_valid      = uv;
    uart_frame_flat = ud;
    cycle();
  endtask

  task automatic idle(input logic s);
    drive(s, 1'b0, rand_frame(), 1'b0, rand_frame());
  endtask

  logic [FW-1:0] fa;
  logic [FW-1:0] fb;
  logic [FW-1:0] saved_cube;

  initial begin
    compared   = 0;
    mismatched = 0;
    pulses     = 0;
    resetn          = 1'b0;
    display_mode    = 2'b00;
    sync            = 1'b0;
    gen_valid       = 1'b0;
    uart_valid      = 1'b0;
    gen_frame_flat  = '0;
    uart_frame_flat = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    resetn = 1'b1;
    idle(1'b1);

    // Gen mode stream: one frame per sync period, UART traffic is discarded.
    display_mode = 2'b10;
    idle(1'b1);
    chk("gen_owner", FW'(owner), FW'(2'b10));
    pulses = 0;
    for (int p = 0; p < 10; p++) begin
      drive(1'b0, 1'b1, rand_frame(), 1'($urandom_range(0, 1)), rand_frame());
      for (int c = 0; c < 18; c++) begin
        drive(1'b0, 1'($urandom_range(0, 3) == 0), rand_frame(),
              1'($urandom_range(0, 1)), rand_frame());
        chk("gen_uart_ready", FW'(uart_ready), FW'(1'b1));
      end
      idle(1'b1);
    end
    chk("gen_pulses", FW'(pulses), FW'(10));
    chk("gen_cnt10", FW'(frame_cnt), FW'(10 % (1 << CW)));

    // Slot-full backpressure: A held, B stalls until after the sync.
    idle(1'b1);
    fa = rand_frame();
    fb = rand_frame();
    drive(1'b0, 1'b1, fa, 1'b0, '0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, fb, 1'b0, '0);
    chk("bp_ready_low", FW'(gen_ready), FW'(1'b0));
    drive(1'b1, 1'b1, fb, 1'b0, '0);
    chk("bp_out_a", frame_cube_flat, fa);
    chk("bp_pulse", FW'(frame_valid), FW'(1'b1));
    drive(1'b0, 1'b1, fb, 1'b0, '0);
    idle(1'b0);
    idle(1'b1);
    chk("bp_out_b", frame_cube_flat, fb);

    // Auto mode: one UART frame, then silence longer than the timeout.
    display_mode = 2'b01;
    drive(1'b0, 1'b0, '0, 1'b1, rand_frame());
    idle(1'b1);
`ifdef ARB_AUTO_FALLBACK_EN
    chk("auto_uart", FW'(owner), FW'(2'b11));
`else
    chk("auto_none", FW'(owner), FW'(2'b00));
`endif
    for (int i = 0; i < TO + 5; i++) idle(1'b0);
    idle(1'b1);
`ifdef ARB_AUTO_FALLBACK_EN
    chk("auto_fallback", FW'(owner), FW'(2'b10));
`else
    chk("auto_still_none", FW'(owner), FW'(2'b00));
`endif
    chk("auto_cnt_clr", FW'(frame_cnt), FW'(0));

    // Mode 11 with a full slot, then switch to static.
    display_mode = 2'b11;
    idle(1'b1);
    drive(1'b0, 1'b0, '0, 1'b1, rand_frame());
    chk("uart_full_ready", FW'(uart_ready), FW'(1'b0));
    saved_cube   = m_cube;
    display_mode = 2'b00;
    idle(1'b1);
    chk("static_owner", FW'(owner), FW'(2'b00));
    chk("static_no_pulse", FW'(frame_valid), FW'(1'b0));
    chk("static_hold", frame_cube_flat, saved_cube);
    chk("static_readies", FW'({uart_ready, gen_ready}), FW'(2'b11));

    // Capture and sync in the same cycle with an empty slot.
    display_mode = 2'b10;
    idle(1'b1);
    fa = rand_frame();
    drive(1'b1, 1'b1, fa, 1'b0, '0);
    chk("same_cycle_no_pulse", FW'(frame_valid), FW'(1'b0));
    idle(1'b0);
    idle(1'b1);
    chk("same_cycle_release", frame_cube_flat, fa);

    // Counter wrap at 2^CNT_W.
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, 1'b1, rand_frame(), 1'b0, '0);
      idle(1'b1);
    end
    chk("cnt_wrap", FW'(frame_cnt), FW'(19 % (1 << CW)));

    // Random mix of modes, syncs and traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) display_mode = 2'($urandom_range(0, 3));
      drive(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0), rand_frame(),
            1'($urandom_range(0, 3) == 0), rand_frame());
    end

    // Asynchronous reset with a pending frame.
    display_mode = 2'b10;
    idle(1'b1);
    idle(1'b1);
    drive(1'b0, 1'b1, rand_frame(), 1'b0, '0);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    resetn = 1'b1;
    idle(1'b1);
    idle(1'b1);
    chk("post_reset_no_pulse", FW'(frame_valid), FW'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
